instr_encoder: RTL and testbench

- Sequential instruction encoder and loader: accepts decoded operation requests (operation class plus fields) over a valid/ready handshake.
- Packs each request into a 32-bit instruction word using the processor's opcode map: R = 000000, MOVI = 001010, ADDI = 001000, SUBI = 001001, J = 000010.
- Streams the words into instruction memory at consecutive word addresses.
- Used by the testbench and boot path to fill program memory that the control unit later decodes.

---
 rtl/instr_encoder.sv | 200 ++++++++++++++++++++
 tb/tb_instr_encoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Purpose : packs decoded operation requests into 32-bit instruction words and writes them to consecutive imem addresses.
// Latency : 1 cycle from accept to wr_en/wr_addr/wr_data; done and count are registered alongside the write.
// Backpres: in_ready is high only in LOAD without start; FULL holds in_ready low until the next start.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle pulse: (re)start a load session at address 0
//   in_valid/in_ready/in_last  request handshake, in_last marks the final request
//   in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target   decoded request fields
//   wr_en, wr_addr, wr_data    instruction-memory write port (one word per strobe)
//   busy, full, done, count    session status; count = words written this session
//   err                        sticky illegal-op flag, present only when ENC_CHECK_EN is defined
//
// Build option ENC_CHECK_EN: illegal ops (5-7) are consumed without a write and raise err.
// Without it, illegal ops are written as 32'h00000000 and advance the address.

module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              full,
    output logic              done,
`ifdef ENC_CHECK_EN
    output logic              err,
`endif
    output logic [ADDR_W:0]   count
);

    // Operation classes as presented on in_op.
    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_MOVI = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SUBI = 3'd3;
    localparam logic [2:0] OP_J    = 3'd4;

    // Processor opcode map.
    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_MOVI = 6'b001010;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_SUBI = 6'b001001;
    localparam logic [5:0] OPC_J    = 6'b000010;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    // Request fields bundled so the encoder sees one value.
    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } req_t;

    state_t            state;
    state_t            state_nxt;
    req_t              req;
    logic              accept;
    logic              do_write;
    logic [ADDR_W-1:0] addr;

    assign req = '{op:     in_op,
                   rs:     in_rs,
                   rt:     in_rt,
                   rd:     in_rd,
                   shamt:  in_shamt,
                   funct:  in_funct,
                   imm:    in_imm,
                   target: in_target};

    // Fields not used by a format are dropped; illegal ops encode as all-zero.
    function automatic logic [31:0] encode(input req_t r);
        logic [31:0] w;
        w = 32'h0000_0000;
        case (r.op)
            OP_R:    w = {OPC_R, r.rs, r.rt, r.rd, r.shamt, r.funct};
            OP_MOVI: w = {OPC_MOVI, r.rs, r.rt, r.imm};
            OP_ADDI: w = {OPC_ADDI, r.rs, r.rt, r.imm};
            OP_SUBI: w = {OPC_SUBI, r.rs, r.rt, r.imm};
            OP_J:    w = {OPC_J, r.target};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: handshake and next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        // A start cycle is a restart boundary: nothing is taken on it, so
        // no request can land on the old session's addresses.
        in_ready  = (state == S_LOAD) && !start;
        accept    = in_valid && in_ready;
`ifdef ENC_CHECK_EN
        do_write  = accept && (in_op <= OP_J);
`else
        do_write  = accept;
`endif
        if (start) begin
            state_nxt = S_LOAD;
        end else if (accept) begin
            // in_last wins over the last address: the session closes cleanly.
            if (in_last) begin
                state_nxt = S_IDLE;
            end else if (do_write && (addr == LAST_ADDR)) begin
                state_nxt = S_FULL;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address / count / write port / status
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr    <= '0;
            count   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            full    <= 1'b0;
        end else begin
            wr_en <= do_write;
            done  <= accept && in_last;
            busy  <= (state_nxt != S_IDLE);
            full  <= (state_nxt == S_FULL);

            if (start) begin
                addr  <= '0;
                count <= '0;
            end else if (do_write) begin
                // Hold at the top address; FULL then blocks further writes,
                // so the pointer never wraps onto already loaded words.
                if (addr != LAST_ADDR) begin
                    addr <= addr + 1'b1;
                end
                count <= count + 1'b1;
            end

            // Port holds its last word while wr_en is low.
            if (do_write) begin
                wr_addr <= addr;
                wr_data <= encode(req);
            end
        end
    end

`ifdef ENC_CHECK_EN
    // Sticky until the next session or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (start) begin
            err <= 1'b0;
        end else if (accept && (in_op > OP_J)) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    // Opcode per operation class 0..4 (R, MOVI, ADDI, SUBI, J).
    localparam int OPC [5] = '{0, 10, 8, 9, 2};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [2:0]    in_op;
    logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]    in_funct;
    logic [15:0]   in_imm;
    logic [25:0]   in_target;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy, full, done;
    logic [AW:0]   count;
`ifdef ENC_CHECK_EN
    logic          err;
`endif

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_funct  (in_funct),
        .in_imm    (in_imm),
        .in_target (in_target),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .full      (full),
        .done      (done),
`ifdef ENC_CHECK_EN
        .err       (err),
`endif
        .count     (count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction word computed arithmetically from the field positions.
    function automatic logic [31:0] ref_word(input int op, input int rs, input int rt, input int rd,
                                             input int sh, input int fn, input int imm, input int tgt);
        longint w;
        if (op == 0)
            w = rs * 2097152 + rt * 65536 + rd * 2048 + sh * 64 + fn;
        else if (op >= 1 && op <= 3)
            w = longint'(OPC[op]) * 67108864 + rs * 2097152 + rt * 65536 + imm;
        else if (op == 4)
            w = longint'(OPC[4]) * 67108864 + tgt;
        else
            w = 0;
        return w[31:0];
    endfunction

    // Session-level model: open session, full, words written, sticky error.
    bit          m_active, m_full, m_err;
    int          m_n;
    bit          e_wr, e_done;
    int          e_addr;
    logic [31:0] e_data;

    task automatic model_reset();
        m_active = 0; m_full = 0; m_err = 0; m_n = 0;
    endtask

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic tick();
        bit acc, legal, wr;
        #1;
        chk("in_ready", in_ready, 32'(m_active && !start));
        acc = in_valid && m_active && !start;
        @(posedge clk);
        #1;
        e_wr = 0; e_done = 0;
        if (start) begin
            m_active = 1; m_full = 0; m_n = 0; m_err = 0;
        end else if (acc) begin
            legal = (in_op <= 3'd4);
`ifdef ENC_CHECK_EN
            if (!legal) m_err = 1;
            wr = legal;
`else
            wr = 1;
`endif
            if (wr) begin
                e_wr   = 1;
                e_addr = m_n;
                e_data = ref_word(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd),
                                  int'(in_shamt), int'(in_funct), int'(in_imm), int'(in_target));
                m_n++;
            end
            if (in_last) begin
                m_active = 0; e_done = 1;
            end else if (m_n == DEPTH) begin
                m_active = 0; m_full = 1;
            end
        end
        chk("wr_en", wr_en, 32'(e_wr));
        if (e_wr) begin
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_data", wr_data, e_data);
        end
        chk("done",  done,  32'(e_done));
        chk("busy",  busy,  32'(m_active || m_full));
        chk("full",  full,  32'(m_full));
        chk("count", count, m_n);
`ifdef ENC_CHECK_EN
        chk("err", err, 32'(m_err));
`endif
    endtask

    task automatic set_req(input int op, input int rs, input int rt, input int rd, input int sh,
                           input int fn, input int imm, input int tgt, input bit last);
        in_op = 3'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd); in_shamt = 5'(sh);
        in_funct = 6'(fn); in_imm = 16'(imm); in_target = 26'(tgt); in_last = last;
    endtask

    task automatic pulse_start();
        in_valid = 0; start = 1;
        tick();
        start = 0;
    endtask

    typedef struct {
        bit          first;
        int          op, rs, rt, rd, sh, fn, imm, tgt;
        bit          last;
        int          exp_addr;
        logic [31:0] exp_data;
        bit          exp_done;
    } vec_t;

    vec_t vt [8];

    initial begin
        // first  op rs rt rd sh fn    imm     tgt   last addr data          done
        vt[0] = '{1, 2, 1, 2, 0, 0, 0,    5,      0,    1, 0, 32'h20220005, 1};
        vt[1] = '{1, 0, 1, 2, 3, 0, 'h20, 0,      0,    0, 0, 32'h00221820, 0};
        vt[2] = '{0, 3, 2, 2, 0, 0, 0,    1,      0,    0, 1, 32'h24420001, 0};
        vt[3] = '{0, 4, 0, 0, 0, 0, 0,    0,      'h10, 1, 2, 32'h08000010, 1};
        vt[4] = '{1, 1, 0, 4, 0, 0, 0,    'hFFFF, 0,    0, 0, 32'h2804FFFF, 0};
        vt[5] = '{0, 1, 0, 4, 0, 0, 0,    'hFFFF, 0,    0, 1, 32'h2804FFFF, 0};
        vt[6] = '{0, 1, 0, 4, 0, 0, 0,    'hFFFF, 0,    0, 2, 32'h2804FFFF, 0};
        vt[7] = '{0, 1, 0, 4, 0, 0, 0,    'hFFFF, 0,    0, 3, 32'h2804FFFF, 0};

        rst_n = 0; start = 0; in_valid = 0;
        set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // Reset state
        #12;
        chk("rst wr_en", wr_en, 0);     chk("rst wr_addr", wr_addr, 0);
        chk("rst wr_data", wr_data, 0); chk("rst busy", busy, 0);
        chk("rst full", full, 0);       chk("rst done", done, 0);
        chk("rst count", count, 0);     chk("rst in_ready", in_ready, 0);
`ifdef ENC_CHECK_EN
        chk("rst err", err, 0);
`endif
        rst_n = 1;
        @(posedge clk); #1;

        // Directed vectors, back to back within a session
        for (int i = 0; i < 8; i++) begin
            if (vt[i].first) pulse_start();
            set_req(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sh, vt[i].fn,
                    vt[i].imm, vt[i].tgt, vt[i].last);
            in_valid = 1;
            tick();
            chk($sformatf("vec%0d wr_en", i),   wr_en,   1);
            chk($sformatf("vec%0d wr_addr", i), wr_addr, vt[i].exp_addr);
            chk($sformatf("vec%0d wr_data", i), wr_data, vt[i].exp_data);
            chk($sformatf("vec%0d done", i),    done,    32'(vt[i].exp_done));
            if (i == 0) chk("vec0 count", count, 1);
        end

        // Memory exhausted: a 5th request stays pending
        for (int i = 0; i < 3; i++) tick();
        chk("full flag", full, 1);
        chk("full in_ready", in_ready, 0);
        chk("full no write", wr_en, 0);
        chk("full count", count, DEPTH);

        // Restart from FULL, then start again while sitting at addr 3 with in_valid high
        pulse_start();
        set_req(0, 7, 8, 9, 1, 'h22, 0, 0, 0);
        in_valid = 1;
        for (int i = 0; i < 3; i++) tick();
        start = 1;
        #1;
        chk("restart in_ready", in_ready, 0);
        tick();
        chk("restart no write", wr_en, 0);
        chk("restart count", count, 0);
        start = 0;
        tick();
        chk("restart addr", wr_addr, 0);
        chk("restart count1", count, 1);
        in_last = 1;
        tick();
        in_last = 0; in_valid = 0;
        tick();

        // Illegal op handling
        pulse_start();
        set_req(2, 1, 2, 0, 0, 0, 3, 0, 0);
        in_valid = 1;
        tick();
        set_req(6, 1, 2, 3, 4, 5, 6, 7, 0);
        tick();
`ifdef ENC_CHECK_EN
        chk("illegal no write", wr_en, 0);
        chk("illegal err", err, 1);
`else
        chk("illegal wr_en", wr_en, 1);
        chk("illegal data", wr_data, 0);
        chk("illegal addr", wr_addr, 1);
`endif
        set_req(3, 1, 1, 0, 0, 0, 9, 0, 0);
        tick();
`ifdef ENC_CHECK_EN
        chk("after illegal addr", wr_addr, 1);
`else
        chk("after illegal addr", wr_addr, 2);
`endif
        set_req(7, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        chk("illegal last done", done, 1);
`ifdef ENC_CHECK_EN
        chk("illegal last no write", wr_en, 0);
`endif
        in_valid = 0; in_last = 0;
        tick();

        // Asynchronous reset between edges
        pulse_start();
        set_req(1, 0, 4, 0, 0, 0, 'hFFFF, 0, 0);
        in_valid = 1;
        tick();
        tick();
        #3;
        rst_n = 0;
        #1;
        chk("arst wr_en", wr_en, 0);     chk("arst wr_addr", wr_addr, 0);
        chk("arst wr_data", wr_data, 0); chk("arst busy", busy, 0);
        chk("arst full", full, 0);       chk("arst done", done, 0);
        chk("arst count", count, 0);     chk("arst in_ready", in_ready, 0);
`ifdef ENC_CHECK_EN
        chk("arst err", err, 0);
`endif
        model_reset();
        #2;
        rst_n = 1; in_valid = 0;
        tick();

        // Randomized sessions against the model
        for (int c = 0; c < 2000; c++) begin
            if (!m_active) start = ($urandom_range(0, 3) == 0);
            else           start = ($urandom_range(0, 29) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 8) in_op = 3'($urandom_range(0, 4));
            else                          in_op = 3'($urandom_range(5, 7));
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_shamt = 5'($urandom); in_funct = 6'($urandom);
            in_imm = 16'($urandom); in_target = 26'($urandom);
            in_last = ($urandom_range(0, 5) == 0);
            tick();
        end
        start = 0; in_valid = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
